dds_sweep_ctrl: RTL

Sequencer that drives the DDS datapath's frequency control word (phase-accumulator key) and waveform select (ROM sel).
- Idle: passes the manual switch settings through.
- On a start pulse, runs one programmed sequence, stepping settings at a dwell rate set in ticks of the 10 kHz strobe: linear up-sweep, triangle sweep, or waveform auto-cycle.
- Sits between the switch inputs and the accumulator/ROM. Emits point_valid so the frequency-measurement logic can restart per point.

---
 rtl/dds_sweep_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Purpose : sequencer driving the DDS frequency control word (key) and waveform select (sel).
// Latency : outputs are registered; passthrough is 1 cycle and the first point appears 1 cycle after start.
// Backpr. : none; tick_en paces each point, stop_req aborts, start is ignored unless idle.
//
// Ports:
//   sys_clk, rst        clock, synchronous active-high reset
//   tick_en             10 kHz strobe, the dwell time base
//   mode, start         sequence select (latched at start) and start pulse
//   stop_req            abort an active sequence
//   key_man, sel_man    manual settings (key_man is also the fixed key in wave-cycle)
//   f_start/f_stop/step sweep range and increment; dwell = ticks per point
//   key_out, sel_out    to phase accumulator / waveform ROM
//   busy, point_valid, done, aborted  status and pulses
module dds_sweep_ctrl #(
    parameter int FCW_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic               stop_req,
    input  logic [FCW_W-1:0]   key_man,
    input  logic [1:0]         sel_man,
    input  logic [FCW_W-1:0]   f_start,
    input  logic [FCW_W-1:0]   f_stop,
    input  logic [FCW_W-1:0]   step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   key_out,
    output logic [1:0]         sel_out,
    output logic               busy,
    output logic               point_valid,
    output logic               done,
    output logic               aborted
);

    localparam logic [1:0] MODE_MAN  = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;
    localparam logic [1:0] MODE_WAVE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [FCW_W-1:0]   r_fstart;
    logic [FCW_W-1:0]   r_fstop;
    logic [FCW_W-1:0]   r_step;      // already clamped to >= 1
    logic [DWELL_W-1:0] r_dwell;     // already clamped to >= 1
    logic [DWELL_W-1:0] r_cnt;
    logic               r_dir_dn;
    logic [FCW_W-1:0]   r_key;
    logic [1:0]         r_sel;
    logic               r_busy;
    logic               r_pv;
    logic               r_done;
    logic               r_abort;

    // Zero step or dwell would stall the sequence forever, so both clamp to 1.
    logic [FCW_W-1:0]   w_step_eff;
    logic [DWELL_W-1:0] w_dwell_eff;
    assign w_step_eff  = (step  == '0) ? FCW_W'(1)   : step;
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Range checks carry one extra bit so key+step and f_start+step never wrap.
    logic [FCW_W:0]     w_up_sum;
    logic [FCW_W:0]     w_dn_lim;
    logic               w_up_ok;
    logic               w_dn_ok;
    assign w_up_sum = {1'b0, r_key} + {1'b0, r_step};
    assign w_dn_lim = {1'b0, r_fstart} + {1'b0, r_step};
    assign w_up_ok  = (w_up_sum <= {1'b0, r_fstop});
    // key - step >= f_start, rearranged to avoid underflow
    assign w_dn_ok  = ({1'b0, r_key} >= w_dn_lim);

    logic [DWELL_W-1:0] w_cnt_inc;
    logic               w_last_tick;
    assign w_cnt_inc   = r_cnt + DWELL_W'(1);
    assign w_last_tick = tick_en && (w_cnt_inc == r_dwell);

    // Next-point decision, used only when the current point's dwell ends.
    logic               w_adv;
    logic [FCW_W-1:0]   w_nkey;
    logic [1:0]         w_nsel;
    logic               w_ndir;
    always_comb begin
        w_adv  = 1'b0;
        w_nkey = r_key;
        w_nsel = r_sel;
        w_ndir = r_dir_dn;
        case (r_mode)
            MODE_UP: begin
                if (w_up_ok) begin
                    w_adv  = 1'b1;
                    w_nkey = r_key + r_step;
                end
            end
            MODE_TRI: begin
                if (!r_dir_dn && w_up_ok) begin
                    w_adv  = 1'b1;
                    w_nkey = r_key + r_step;
                end else if (w_dn_ok) begin
                    // covers both the turn-around at the top and the down phase
                    w_adv  = 1'b1;
                    w_ndir = 1'b1;
                    w_nkey = r_key - r_step;
                end
            end
            MODE_WAVE: begin
                if (r_sel != 2'd3) begin
                    w_adv  = 1'b1;
                    w_nsel = r_sel + 2'd1;
                end
            end
            default: begin
                w_adv = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_MAN;
            r_fstart <= '0;
            r_fstop  <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_dir_dn <= 1'b0;
            r_key    <= '0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_pv     <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_pv    <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_key  <= key_man;
                    r_sel  <= sel_man;
                    r_busy <= 1'b0;
                    if (start && (mode != MODE_MAN)) begin
                        r_state  <= S_DWELL;
                        r_mode   <= mode;
                        r_fstart <= f_start;
                        r_fstop  <= f_stop;
                        r_step   <= w_step_eff;
                        r_dwell  <= w_dwell_eff;
                        r_cnt    <= '0;
                        r_dir_dn <= 1'b0;
                        r_busy   <= 1'b1;
                        r_pv     <= 1'b1;
                        if (mode == MODE_WAVE) begin
                            r_key <= key_man;
                            r_sel <= 2'd0;
                        end else begin
                            r_key <= f_start;
                            r_sel <= sel_man;
                        end
                    end
                end
                S_DWELL: begin
                    if (stop_req) begin
                        // abort beats a coincident final tick; outputs go straight back to manual
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abort <= 1'b1;
                        r_key   <= key_man;
                        r_sel   <= sel_man;
                    end else if (w_last_tick) begin
                        r_cnt <= '0;
                        if (w_adv) begin
                            r_key    <= w_nkey;
                            r_sel    <= w_nsel;
                            r_dir_dn <= w_ndir;
                            r_pv     <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (tick_en) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    // outputs hold the last point for one more cycle in IDLE
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_out     = r_key;
    assign sel_out     = r_sel;
    assign busy        = r_busy;
    assign point_valid = r_pv;
    assign done        = r_done;
    assign aborted     = r_abort;

endmodule
